// File: rtl/hs32_memarb.sv
// hs32_memarb: NCH-channel arbiter sharing one memory port through an IDLE/BUSY/DONE handshake.
// Define HS32_MEMARB_RR_EN for round-robin arbitration; otherwise the lowest-index request wins.
module hs32_memarb #(
    parameter int NCH = 4,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [AW-1:0]     addr,
    output logic              rw,
    output logic [DW-1:0]     dout,
    input  logic [DW-1:0]     din,
    output logic              valid,
    input  logic              ready,
    input  logic [NCH*AW-1:0] addr_in,
    input  logic [NCH-1:0]    rw_in,
    input  logic [NCH*DW-1:0] dtw,
    input  logic [NCH-1:0]    req,
    output logic [DW-1:0]     dtr,
    output logic [NCH-1:0]    rdy,
    output logic [NCH-1:0]    gnt
);
    localparam int IW = $clog2(NCH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t         r_state, w_next;
    logic [IW-1:0]  w_sel;
    logic           w_take;
    logic [AW-1:0]  r_addr;
    logic           r_rw;
    logic [DW-1:0]  r_dout, r_dtr;
    logic [NCH-1:0] r_gnt;
    assign w_take = (r_state == IDLE) && (|req);
`ifdef HS32_MEMARB_RR_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    // Descending scan: the last hit is the first requester after the last owner.
    always_comb begin
        w_sel = '0;
        w_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + 1 + k) % NCH);
            if (req[w_idx]) w_sel = w_idx;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_ptr <= IW'(NCH - 1);
        else if (w_take) r_ptr <= w_sel;
`else
    always_comb begin
        w_sel = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (req[IW'(k)]) w_sel = IW'(k);
    end
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (|req) ? BUSY : IDLE;
            BUSY:    w_next = ready ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        valid = (r_state == BUSY);
        rdy   = (r_state == DONE) ? r_gnt : '0;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_addr <= '0;
            r_rw   <= 1'b0;
            r_dout <= '0;
            r_dtr  <= '0;
            r_gnt  <= '0;
        end else if (w_take) begin
            r_addr <= addr_in[int'(w_sel) * AW +: AW];
            r_rw   <= rw_in[w_sel];
            r_dout <= dtw[int'(w_sel) * DW +: DW];
            r_gnt  <= NCH'(1) << w_sel;
        end else if (r_state == BUSY && ready) begin
            r_dtr <= din;
        end else if (r_state == DONE) begin
            r_gnt <= '0;
        end
    assign addr = r_addr;
    assign rw   = r_rw;
    assign dout = r_dout;
    assign dtr  = r_dtr;
    assign gnt  = r_gnt;
endmodule

// File: tb/tb_hs32_memarb.sv
// tb_hs32_memarb: directed vector table plus hand-written corner sequences for hs32_memarb (NCH=4).
module tb_hs32_memarb;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  addr, dout, din, dtr;
    logic         rw, valid, ready;
    logic [127:0] addr_in, dtw;
    logic [3:0]   rw_in, req, rdy, gnt;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic        rd;
        logic [31:0] din;
        logic        valid;
        logic [3:0]  gnt;
        logic [3:0]  rdy;
        logic [31:0] addr;
        logic [31:0] dtr;
    } vec_t;
    vec_t tbl[12];

    hs32_memarb #(.NCH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rw(rw), .dout(dout), .din(din),
        .valid(valid), .ready(ready), .addr_in(addr_in), .rw_in(rw_in), .dtw(dtw),
        .req(req), .dtr(dtr), .rdy(rdy), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req = '0;
        ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  g2;
        logic [31:0] a2;
        logic [3:0]  rr_exp[5];
        int          extra;
        addr_in = {32'h130, 32'h120, 32'h110, 32'h100};
        dtw     = {32'hD003, 32'hD002, 32'hD001, 32'hD000};
        rw_in = '0;
        req = '0;
        ready = 1'b0;
        din = '0;
`ifdef HS32_MEMARB_RR_EN
        g2 = 4'b1000;
        a2 = 32'h130;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        g2 = 4'b0010;
        a2 = 32'h110;
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        tbl[0]  = '{4'b0000, 1'b0, 32'h0,    1'b0, 4'b0000, 4'b0000, 32'h0,   32'h0};
        tbl[1]  = '{4'b0001, 1'b0, 32'h0,    1'b1, 4'b0001, 4'b0000, 32'h100, 32'h0};
        tbl[2]  = '{4'b0001, 1'b0, 32'h0,    1'b1, 4'b0001, 4'b0000, 32'h100, 32'h0};
        tbl[3]  = '{4'b0001, 1'b1, 32'hCAFE, 1'b0, 4'b0001, 4'b0001, 32'h100, 32'hCAFE};
        tbl[4]  = '{4'b0000, 1'b0, 32'h0,    1'b0, 4'b0000, 4'b0000, 32'h100, 32'hCAFE};
        tbl[5]  = '{4'b1010, 1'b0, 32'h0,    1'b1, 4'b0010, 4'b0000, 32'h110, 32'hCAFE};
        tbl[6]  = '{4'b1010, 1'b1, 32'h1111, 1'b0, 4'b0010, 4'b0010, 32'h110, 32'h1111};
        tbl[7]  = '{4'b1010, 1'b1, 32'h2222, 1'b0, 4'b0000, 4'b0000, 32'h110, 32'h1111};
        tbl[8]  = '{4'b1010, 1'b1, 32'h3333, 1'b1, g2,      4'b0000, a2,      32'h1111};
        tbl[9]  = '{4'b1010, 1'b0, 32'h0,    1'b1, g2,      4'b0000, a2,      32'h1111};
        tbl[10] = '{4'b1010, 1'b1, 32'h4444, 1'b0, g2,      g2,      a2,      32'h4444};
        tbl[11] = '{4'b0000, 1'b0, 32'h0,    1'b0, 4'b0000, 4'b0000, a2,      32'h4444};

        #1;
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rdy", 32'(rdy), 32'h0);
        chk("reset_addr", addr, 32'h0);
        chk("reset_rw", 32'(rw), 32'h0);
        chk("reset_dout", dout, 32'h0);
        chk("reset_dtr", dtr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req = tbl[i].req;
            ready = tbl[i].rd;
            din = tbl[i].din;
            step();
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
            chk($sformatf("v%0d_dtr", i), dtr, tbl[i].dtr);
        end

        // Hold stability: request fields change and req drops while BUSY.
        @(negedge clk);
        req = 4'b0100;
        step();
        chk("hold_grant", 32'(gnt), 32'h4);
        @(negedge clk);
        addr_in[64 +: 32] = 32'h200;
        rw_in = 4'b0100;
        dtw[64 +: 32] = 32'hBEEF;
        req = '0;
        step();
        chk("hold_addr", addr, 32'h120);
        chk("hold_rw", 32'(rw), 32'h0);
        chk("hold_dout", dout, 32'hD002);
        chk("hold_gnt", 32'(gnt), 32'h4);
        chk("hold_valid", 32'(valid), 32'h1);
        @(negedge clk);
        ready = 1'b1;
        din = 32'h7777;
        step();
        chk("hold_rdy", 32'(rdy), 32'h4);
        chk("hold_dtr", dtr, 32'h7777);
        @(negedge clk);
        ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rdy != 0) extra++;
        end
        chk("hold_rdy_extra", 32'(extra), 32'h0);
        addr_in[64 +: 32] = 32'h120;
        rw_in = '0;

        // Write on channel 2.
        @(negedge clk);
        req = 4'b0100;
        rw_in = 4'b0100;
        dtw[64 +: 32] = 32'hDEAD;
        step();
        chk("wr_rw", 32'(rw), 32'h1);
        chk("wr_dout", dout, 32'hDEAD);
        chk("wr_rdy_early", 32'(rdy), 32'h0);
        @(negedge clk);
        ready = 1'b1;
        din = 32'h5555;
        step();
        chk("wr_rdy", 32'(rdy), 32'h4);
        chk("wr_dtr", dtr, 32'h5555);
        @(negedge clk);
        req = '0;
        ready = 1'b0;
        rw_in = '0;
        step();
        chk("wr_rdy_clear", 32'(rdy), 32'h0);

        // Reset asserted mid-BUSY, away from any clock edge.
        @(negedge clk);
        req = 4'b0001;
        step();
        chk("rst_busy", 32'(valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(valid), 32'h0);
        chk("rst_async_gnt", 32'(gnt), 32'h0);
        chk("rst_async_rdy", 32'(rdy), 32'h0);
        chk("rst_async_addr", addr, 32'h0);
        chk("rst_async_dtr", dtr, 32'h0);
        ready = 1'b1;
        step();
        step();
        chk("rst_no_sample", 32'(valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        req = '0;
        ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rdy != 0 || valid) extra++;
        end
        chk("rst_no_rdy_after", 32'(extra), 32'h0);
        @(negedge clk);
        req = 4'b1010;
        step();
        chk("rst_first_grant", 32'(gnt), 32'h2);
        @(negedge clk);
        ready = 1'b1;
        step();
        chk("rst_first_rdy", 32'(rdy), 32'h2);

        // All channels requesting, ready every BUSY cycle.
        do_reset();
        req = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("all_gnt%0d", k), 32'(gnt), 32'(rr_exp[k]));
            chk($sformatf("all_valid%0d", k), 32'(valid), 32'h1);
            step();
            chk($sformatf("all_rdy%0d", k), 32'(rdy), 32'(rr_exp[k]));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
